// File: rtl/bp_cce_msg_buffer_mc_pkg.sv
// Shared types for the CCE multi-channel message buffer.
package bp_me_pkg;

  typedef enum logic {
    e_buf_ready_valid = 1'b0,
    e_buf_credit      = 1'b1
  } bp_cce_buf_mode_e;

endpackage

// File: rtl/bp_cce_msg_buffer_mc_chan.sv
// One channel of the CCE message buffer: circular storage, pointers, count, credit and overflow.
// Optional same-cycle bypass of an empty channel under `BP_CCE_BUF_BYPASS_EN`.
module bp_cce_buf_chan
  import bp_me_pkg::*;
#(
  parameter int width_p       = 64,
  parameter int els_p         = 2,
  parameter int credit_mode_p = 0,
  parameter int cnt_width_lp  = $clog2(els_p+1)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [width_p-1:0]      data_i,
  input  logic                    v_i,
  output logic                    ready_o,
  output logic                    credit_o,
  output logic [width_p-1:0]      data_o,
  output logic                    v_o,
  input  logic                    yumi_i,
  output logic [cnt_width_lp-1:0] count_o,
  output logic                    overflow_o
);

  localparam int                      ptr_width_lp = $clog2(els_p);
  localparam logic [ptr_width_lp-1:0] last_ptr_lp  = ptr_width_lp'(els_p - 1);
  localparam logic [cnt_width_lp-1:0] full_cnt_lp  = cnt_width_lp'(els_p);
  localparam bit credit_en_lp = (credit_mode_p == int'(e_buf_credit));

  logic [width_p-1:0]      r_mem [els_p];
  logic [ptr_width_lp-1:0] r_rptr;
  logic [ptr_width_lp-1:0] r_wptr;
  logic [cnt_width_lp-1:0] r_count;
  logic                    r_credit;
  logic                    r_overflow;

  logic w_full;
  logic w_empty;
  logic w_accept;
  logic w_byp;
  logic w_deq;
  logic w_rd;
  logic w_wr;

  assign w_full   = (r_count == full_cnt_lp);
  assign w_empty  = (r_count == '0);
  // ready and the credit-mode full check share one source: the registered count
  assign w_accept = v_i & ~w_full;

`ifdef BP_CCE_BUF_BYPASS_EN
  assign w_byp  = w_empty & w_accept;
  assign v_o    = ~w_empty | w_byp;
  assign data_o = w_empty ? data_i : r_mem[r_rptr];
`else
  assign w_byp  = 1'b0;
  assign v_o    = ~w_empty;
  assign data_o = r_mem[r_rptr];
`endif

  assign w_deq = yumi_i & v_o;
  // a bypassed message that is consumed at once never touches storage
  assign w_rd  = w_deq & ~w_empty;
  assign w_wr  = w_accept & ~(w_byp & yumi_i);

  assign ready_o    = ~w_full;
  assign credit_o   = r_credit;
  assign count_o    = r_count;
  assign overflow_o = r_overflow;

  always_ff @(posedge clk_i) begin
    if (w_wr) r_mem[r_wptr] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_rptr     <= '0;
      r_wptr     <= '0;
      r_count    <= '0;
      r_credit   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) r_wptr <= (r_wptr == last_ptr_lp) ? '0 : r_wptr + 1'b1;
      if (w_rd) r_rptr <= (r_rptr == last_ptr_lp) ? '0 : r_rptr + 1'b1;
      if (w_wr && !w_rd)      r_count <= r_count + 1'b1;
      else if (w_rd && !w_wr) r_count <= r_count - 1'b1;
      r_credit <= credit_en_lp & w_deq;
      if (credit_en_lp && v_i && w_full) r_overflow <= 1'b1;
    end
  end

  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);

endmodule

// File: rtl/bp_cce_msg_buffer_mc.sv
// Multi-channel CCE ingress buffer: num_chan_p independent FIFOs, ready&valid or credit inputs.
// Same-cycle bypass of empty channels is enabled by `BP_CCE_BUF_BYPASS_EN`.
module bp_cce_msg_buffer_mc
  import bp_me_pkg::*;
#(
  parameter int num_chan_p    = 4,
  parameter int width_p       = 64,
  parameter int els_p         = 2,
  parameter int credit_mode_p = 0,
  parameter int cnt_width_lp  = $clog2(els_p+1)
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic [num_chan_p*width_p-1:0]      data_i,
  input  logic [num_chan_p-1:0]              v_i,
  output logic [num_chan_p-1:0]              ready_o,
  output logic [num_chan_p-1:0]              credit_o,
  output logic [num_chan_p*width_p-1:0]      data_o,
  output logic [num_chan_p-1:0]              v_o,
  input  logic [num_chan_p-1:0]              yumi_i,
  output logic [num_chan_p*cnt_width_lp-1:0] count_o,
  output logic [num_chan_p-1:0]              overflow_o
);

  for (genvar c = 0; c < num_chan_p; c++) begin : g_chan
    bp_cce_buf_chan #(
      .width_p      (width_p),
      .els_p        (els_p),
      .credit_mode_p(credit_mode_p),
      .cnt_width_lp (cnt_width_lp)
    ) u_chan (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .data_i    (data_i[c*width_p +: width_p]),
      .v_i       (v_i[c]),
      .ready_o   (ready_o[c]),
      .credit_o  (credit_o[c]),
      .data_o    (data_o[c*width_p +: width_p]),
      .v_o       (v_o[c]),
      .yumi_i    (yumi_i[c]),
      .count_o   (count_o[c*cnt_width_lp +: cnt_width_lp]),
      .overflow_o(overflow_o[c])
    );
  end

endmodule

// File: tb/tb_bp_cce_msg_buffer_mc.sv
// Bench for bp_cce_msg_buffer_mc: a ready&valid instance (els 3) and a credit instance (els 2),
// checked against per-channel queue models; follows `BP_CCE_BUF_BYPASS_EN` when defined.
module tb_bp_cce_msg_buffer_mc;

`ifdef BP_CCE_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  logic [63:0] din  [2];
  logic [3:0]  vin  [2];
  logic [3:0]  yin  [2];
  logic [63:0] dout [2];
  logic [3:0]  vout [2];
  logic [3:0]  rdy  [2];
  logic [3:0]  cred [2];
  logic [3:0]  ovf  [2];
  logic [7:0]  cnt  [2];

  int checks = 0;
  int errors = 0;

  // d=0: ready&valid, 3 entries; d=1: credit, 2 entries
  logic [15:0] mq [2][4][$];
  logic [3:0]  m_cred [2];
  logic [3:0]  m_ovf  [2];

  logic [3:0]  e_v [2], e_rdy [2], e_cred [2], e_ovf [2];
  logic [7:0]  e_cnt [2];
  logic [63:0] e_data [2], e_mask [2];

  always #5 clk = ~clk;

  bp_cce_msg_buffer_mc #(.num_chan_p(4), .width_p(16), .els_p(3), .credit_mode_p(0)) u_rv (
    .clk_i(clk), .reset_n_i(rst_n), .data_i(din[0]), .v_i(vin[0]), .ready_o(rdy[0]),
    .credit_o(cred[0]), .data_o(dout[0]), .v_o(vout[0]), .yumi_i(yin[0]),
    .count_o(cnt[0]), .overflow_o(ovf[0])
  );

  bp_cce_msg_buffer_mc #(.num_chan_p(4), .width_p(16), .els_p(2), .credit_mode_p(1)) u_cr (
    .clk_i(clk), .reset_n_i(rst_n), .data_i(din[1]), .v_i(vin[1]), .ready_o(rdy[1]),
    .credit_o(cred[1]), .data_o(dout[1]), .v_o(vout[1]), .yumi_i(yin[1]),
    .count_o(cnt[1]), .overflow_o(ovf[1])
  );

  function automatic int els_of(int d);
    return (d == 0) ? 3 : 2;
  endfunction

  task automatic idle();
    for (int d = 0; d < 2; d++) begin
      vin[d] = '0;
      yin[d] = '0;
      din[d] = '0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 4; c++) begin
        if (!rst_n) begin
          mq[d][c].delete();
          m_cred[d][c] = 1'b0;
          m_ovf[d][c]  = 1'b0;
        end else begin
          int  sz;
          bit  full, acc, byp, legal;
          sz    = mq[d][c].size();
          full  = (sz == els_of(d));
          acc   = vin[d][c] && !full;
          byp   = BYP && (sz == 0) && acc;
          legal = yin[d][c] && (sz > 0 || byp);
          if (!(byp && yin[d][c])) begin
            if (legal) void'(mq[d][c].pop_front());
            if (acc) mq[d][c].push_back(din[d][c*16 +: 16]);
          end
          m_cred[d][c] = (d == 1) && legal;
          if (d == 1 && vin[d][c] && full) m_ovf[d][c] = 1'b1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic model_outputs();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 4; c++) begin
        int sz;
        bit byp;
        sz  = mq[d][c].size();
        byp = BYP && (sz == 0) && vin[d][c];
        e_cnt[d][c*2 +: 2]   = 2'(sz);
        e_rdy[d][c]          = (sz < els_of(d));
        e_v[d][c]            = (sz > 0) || byp;
        e_data[d][c*16 +: 16] = (sz > 0) ? mq[d][c][0] : din[d][c*16 +: 16];
        e_mask[d][c*16 +: 16] = e_v[d][c] ? 16'hffff : 16'h0000;
        e_cred[d][c]         = m_cred[d][c];
        e_ovf[d][c]          = m_ovf[d][c];
      end
    end
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++; if (vout[d] !== 4'h0) begin errors++; $display("FAIL rst_v d=%0d act=%h exp=0", d, vout[d]); end
      checks++; if (rdy[d] !== 4'hf) begin errors++; $display("FAIL rst_ready d=%0d act=%h exp=f", d, rdy[d]); end
      checks++; if (cred[d] !== 4'h0) begin errors++; $display("FAIL rst_credit d=%0d act=%h exp=0", d, cred[d]); end
      checks++; if (cnt[d] !== 8'h00) begin errors++; $display("FAIL rst_count d=%0d act=%h exp=00", d, cnt[d]); end
      checks++; if (ovf[d] !== 4'h0) begin errors++; $display("FAIL rst_ovf d=%0d act=%h exp=0", d, ovf[d]); end
    end
  endtask

  task automatic test_fill();
    idle();
    for (int k = 1; k <= 3; k++) begin
      vin[0][0] = 1'b1;
      din[0][15:0] = 16'hA000 + 16'(k);
      #1;
      checks++; if (rdy[0][0] !== 1'b1) begin errors++; $display("FAIL fill_ready_pre k=%0d act=%b exp=1", k, rdy[0][0]); end
      tick();
    end
    idle();
    #1;
    checks++; if (cnt[0][1:0] !== 2'd3) begin errors++; $display("FAIL fill_count act=%0d exp=3", cnt[0][1:0]); end
    checks++; if (rdy[0][0] !== 1'b0) begin errors++; $display("FAIL fill_ready_full act=%b exp=0", rdy[0][0]); end
    for (int k = 1; k <= 3; k++) begin
      yin[0][0] = 1'b1;
      #1;
      checks++; if (dout[0][15:0] !== 16'hA000 + 16'(k)) begin errors++; $display("FAIL fill_order k=%0d act=%h exp=%h", k, dout[0][15:0], 16'hA000 + 16'(k)); end
      tick();
    end
    idle();
    #1;
    checks++; if (vout[0][0] !== 1'b0) begin errors++; $display("FAIL fill_empty_v act=%b exp=0", vout[0][0]); end
    checks++; if (cnt[0][1:0] !== 2'd0) begin errors++; $display("FAIL fill_empty_count act=%0d exp=0", cnt[0][1:0]); end
  endtask

  task automatic test_wrap();
    int unsigned nw = 1, nr = 1, guard = 0;
    idle();
    while (nr <= 7 && guard < 100) begin
      vin[0][1]     = (nw <= 7) && ($urandom_range(1, 0) == 1);
      din[0][31:16] = 16'(nw);
      yin[0][1]     = (mq[0][1].size() > 0) && ($urandom_range(1, 0) == 1);
      #1;
      if (yin[0][1]) begin
        checks++; if (dout[0][31:16] !== 16'(nr)) begin errors++; $display("FAIL wrap_order act=%0d exp=%0d", dout[0][31:16], nr); end
        nr++;
      end
      checks++; if (cnt[0][3:2] !== 2'(mq[0][1].size())) begin errors++; $display("FAIL wrap_count act=%0d exp=%0d", cnt[0][3:2], mq[0][1].size()); end
      if (vin[0][1] && mq[0][1].size() < 3) nw++;
      tick();
      guard++;
    end
    idle();
    checks++; if (nr != 8) begin errors++; $display("FAIL wrap_timeout act=%0d exp=8", nr); end
  endtask

  task automatic test_simul();
    idle();
    for (int k = 1; k <= 3; k++) begin
      vin[0][2] = 1'b1;
      din[0][47:32] = 16'hC000 + 16'(k);
      tick();
    end
    vin[0][2] = 1'b1;
    din[0][47:32] = 16'hC099;
    yin[0][2] = 1'b1;
    #1;
    checks++; if (rdy[0][2] !== 1'b0) begin errors++; $display("FAIL simul_ready_full act=%b exp=0", rdy[0][2]); end
    checks++; if (dout[0][47:32] !== 16'hC001) begin errors++; $display("FAIL simul_head act=%h exp=c001", dout[0][47:32]); end
    tick();
    idle();
    #1;
    checks++; if (cnt[0][5:4] !== 2'd2) begin errors++; $display("FAIL simul_count act=%0d exp=2", cnt[0][5:4]); end
    checks++; if (rdy[0][2] !== 1'b1) begin errors++; $display("FAIL simul_ready_after act=%b exp=1", rdy[0][2]); end
    for (int k = 2; k <= 3; k++) begin
      yin[0][2] = 1'b1;
      #1;
      checks++; if (dout[0][47:32] !== 16'hC000 + 16'(k)) begin errors++; $display("FAIL simul_order k=%0d act=%h exp=%h", k, dout[0][47:32], 16'hC000 + 16'(k)); end
      tick();
    end
    idle();
    #1;
    checks++; if (vout[0][2] !== 1'b0) begin errors++; $display("FAIL simul_refused_dropped act=%b exp=0", vout[0][2]); end
  endtask

  task automatic test_credit();
    idle();
    vin[1][0] = 1'b1; din[1][15:0] = 16'hB001; tick();
    din[1][15:0] = 16'hB002; tick();
    idle();
    #1;
    checks++; if (cnt[1][1:0] !== 2'd2) begin errors++; $display("FAIL credit_count_full act=%0d exp=2", cnt[1][1:0]); end
    checks++; if (rdy[1][0] !== 1'b0) begin errors++; $display("FAIL credit_ready_full act=%b exp=0", rdy[1][0]); end
    checks++; if (ovf[1][0] !== 1'b0) begin errors++; $display("FAIL credit_ovf_pre act=%b exp=0", ovf[1][0]); end
    vin[1][0] = 1'b1; din[1][15:0] = 16'hB003; tick();
    idle();
    #1;
    checks++; if (ovf[1][0] !== 1'b1) begin errors++; $display("FAIL credit_ovf_set act=%b exp=1", ovf[1][0]); end
    checks++; if (cnt[1][1:0] !== 2'd2) begin errors++; $display("FAIL credit_count_drop act=%0d exp=2", cnt[1][1:0]); end
    for (int k = 1; k <= 2; k++) begin
      yin[1][0] = 1'b1;
      #1;
      checks++; if (dout[1][15:0] !== 16'hB000 + 16'(k)) begin errors++; $display("FAIL credit_order k=%0d act=%h exp=%h", k, dout[1][15:0], 16'hB000 + 16'(k)); end
      checks++; if (cred[1][0] !== 1'b0) begin errors++; $display("FAIL credit_early k=%0d act=%b exp=0", k, cred[1][0]); end
      tick();
      idle();
      #1;
      checks++; if (cred[1][0] !== 1'b1) begin errors++; $display("FAIL credit_pulse k=%0d act=%b exp=1", k, cred[1][0]); end
      tick();
      checks++; if (cred[1][0] !== 1'b0) begin errors++; $display("FAIL credit_pulse_end k=%0d act=%b exp=0", k, cred[1][0]); end
    end
    checks++; if (vout[1][0] !== 1'b0) begin errors++; $display("FAIL credit_dropped_gone act=%b exp=0", vout[1][0]); end
    checks++; if (ovf[1][0] !== 1'b1) begin errors++; $display("FAIL credit_ovf_sticky act=%b exp=1", ovf[1][0]); end
  endtask

  task automatic test_bypass();
    idle();
    vin[0][3] = 1'b1;
    din[0][63:48] = 16'h5A5A;
    yin[0][3] = BYP;
    #1;
    if (BYP) begin
      checks++; if (vout[0][3] !== 1'b1) begin errors++; $display("FAIL byp_v act=%b exp=1", vout[0][3]); end
      checks++; if (dout[0][63:48] !== 16'h5A5A) begin errors++; $display("FAIL byp_data act=%h exp=5a5a", dout[0][63:48]); end
      tick();
      idle();
      #1;
      checks++; if (cnt[0][7:6] !== 2'd0) begin errors++; $display("FAIL byp_count act=%0d exp=0", cnt[0][7:6]); end
      checks++; if (vout[0][3] !== 1'b0) begin errors++; $display("FAIL byp_v_after act=%b exp=0", vout[0][3]); end
    end else begin
      checks++; if (vout[0][3] !== 1'b0) begin errors++; $display("FAIL nobyp_v_same act=%b exp=0", vout[0][3]); end
      tick();
      idle();
      #1;
      checks++; if (vout[0][3] !== 1'b1) begin errors++; $display("FAIL nobyp_v_next act=%b exp=1", vout[0][3]); end
      checks++; if (dout[0][63:48] !== 16'h5A5A) begin errors++; $display("FAIL nobyp_data act=%h exp=5a5a", dout[0][63:48]); end
      checks++; if (cnt[0][7:6] !== 2'd1) begin errors++; $display("FAIL nobyp_count act=%0d exp=1", cnt[0][7:6]); end
      yin[0][3] = 1'b1;
      tick();
      idle();
    end
  endtask

  task automatic test_reset_mid();
    idle();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int d = 0; d < 2; d++) begin
        vin[d] = 4'hf;
        din[d] = {16'(k + 16'h30), 16'(k + 16'h20), 16'(k + 16'h10), 16'(k)};
      end
      tick();
    end
    idle();
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++; if (cnt[d] !== 8'haa) begin errors++; $display("FAIL rmid_count_pre d=%0d act=%h exp=aa", d, cnt[d]); end
    end
    rst_n = 1'b0;
    yin[1] = 4'hf;
    tick();
    yin[1] = 4'h0;
    tick();
    rst_n = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++; if (cnt[d] !== 8'h00) begin errors++; $display("FAIL rmid_count d=%0d act=%h exp=00", d, cnt[d]); end
      checks++; if (vout[d] !== 4'h0) begin errors++; $display("FAIL rmid_v d=%0d act=%h exp=0", d, vout[d]); end
      checks++; if (cred[d] !== 4'h0) begin errors++; $display("FAIL rmid_credit d=%0d act=%h exp=0", d, cred[d]); end
    end
    tick();
    checks++; if (cred[1] !== 4'h0) begin errors++; $display("FAIL rmid_credit_late act=%h exp=0", cred[1]); end
    for (int d = 0; d < 2; d++) begin
      vin[d][0] = 1'b1;
      din[d][15:0] = 16'h7777;
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++; if (vout[d][0] !== BYP) begin errors++; $display("FAIL rmid_latency_same d=%0d act=%b exp=%b", d, vout[d][0], BYP); end
    end
    tick();
    idle();
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++; if (vout[d][0] !== 1'b1) begin errors++; $display("FAIL rmid_latency_next d=%0d act=%b exp=1", d, vout[d][0]); end
      checks++; if (dout[d][15:0] !== 16'h7777) begin errors++; $display("FAIL rmid_data d=%0d act=%h exp=7777", d, dout[d][15:0]); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      for (int d = 0; d < 2; d++) begin
        vin[d] = 4'($urandom);
        din[d] = {$urandom, $urandom};
      end
      model_outputs();
      for (int d = 0; d < 2; d++) yin[d] = e_v[d] & 4'($urandom);
      #1;
      for (int d = 0; d < 2; d++) begin
        checks++; if (vout[d] !== e_v[d]) begin errors++; $display("FAIL rnd_v n=%0d d=%0d act=%h exp=%h", n, d, vout[d], e_v[d]); end
        checks++; if ((dout[d] & e_mask[d]) !== (e_data[d] & e_mask[d])) begin errors++; $display("FAIL rnd_data n=%0d d=%0d act=%h exp=%h", n, d, dout[d] & e_mask[d], e_data[d] & e_mask[d]); end
        checks++; if (cnt[d] !== e_cnt[d]) begin errors++; $display("FAIL rnd_count n=%0d d=%0d act=%h exp=%h", n, d, cnt[d], e_cnt[d]); end
        checks++; if (rdy[d] !== e_rdy[d]) begin errors++; $display("FAIL rnd_ready n=%0d d=%0d act=%h exp=%h", n, d, rdy[d], e_rdy[d]); end
        checks++; if (cred[d] !== e_cred[d]) begin errors++; $display("FAIL rnd_credit n=%0d d=%0d act=%h exp=%h", n, d, cred[d], e_cred[d]); end
        checks++; if (ovf[d] !== e_ovf[d]) begin errors++; $display("FAIL rnd_ovf n=%0d d=%0d act=%h exp=%h", n, d, ovf[d], e_ovf[d]); end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    for (int d = 0; d < 2; d++) begin
      m_cred[d] = '0;
      m_ovf[d]  = '0;
    end
    test_reset();
    test_fill();
    test_wrap();
    test_simul();
    test_credit();
    test_bypass();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
